// File: rtl/pflink_pkg.sv
// Shared definitions for the PFLINK receive lane monitor: lane states,
// default comma character and lane word width.
package pflink_pkg;
   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_HUNT   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCKED = 2'd3
   } lane_state_t;

   localparam logic [7:0] COMMA_K_DEF = 8'hBC;
   localparam int         LANE_W      = 16;
endpackage

// File: rtl/pflink_lane_fsm.sv
// One receive lane: comma hunt / verify / lock FSM, windowed error monitor,
// byte aligner and (with PFLINK_ERR_CNT_EN) a saturating errored-word counter.
module pflink_lane_fsm
   import pflink_pkg::*;
#(
   parameter logic [7:0] COMMA_K    = COMMA_K_DEF,
   parameter int         LOCK_CNT   = 16,
   parameter int         ERR_THRESH = 4,
   parameter int         ERR_WINDOW = 256,
   parameter int         CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [LANE_W-1:0] rx_d,
   input  logic [1:0]        rx_k,
   input  logic [1:0]        rx_err,
   input  logic              rx_reset_done,
   input  logic              lane_en,
   input  logic              clr_cnt,
   output logic [LANE_W-1:0] out_d,
   output logic              out_valid,
   output logic              lane_locked,
   output logic              relock_req,
   output logic [CNT_W-1:0]  err_cnt
);
   localparam int GC_W  = $clog2(LOCK_CNT + 1);
   localparam int ERR_W = $clog2(ERR_THRESH + 1);
   localparam int WIN_W = $clog2(ERR_WINDOW);

   lane_state_t       state, state_nxt;
   logic [GC_W-1:0]   gc, gc_nxt, gc_inc;
   logic              swap, swap_nxt, drop;
   logic [WIN_W-1:0]  win_cnt;
   logic [ERR_W-1:0]  win_err, win_err_new;
   logic [LANE_W-1:0] prev;
   logic              prev_err;
   logic              errored, comma_lo, comma_hi, comma, force_rst, win_wrap;

   assign errored     = |rx_err;
   assign comma_lo    = rx_k[0] && (rx_d[7:0] == COMMA_K);
   assign comma_hi    = rx_k[1] && (rx_d[15:8] == COMMA_K);
   assign comma       = !errored && (comma_lo || comma_hi);
   assign force_rst   = !lane_en || !rx_reset_done;
   assign gc_inc      = gc + GC_W'(1);
   assign win_wrap    = (win_cnt == WIN_W'(ERR_WINDOW - 1));
   // The wrap cycle's own error opens the new window instead of closing the old one.
   assign win_err_new = (win_wrap ? '0 : win_err) + ERR_W'(errored);

   always_comb begin
      state_nxt = state;
      gc_nxt    = gc;
      swap_nxt  = swap;
      drop      = 1'b0;
      case (state)
         ST_RESET:  state_nxt = ST_HUNT;
         ST_HUNT: begin
            gc_nxt = '0;
            if (comma) begin
               swap_nxt  = !comma_lo;
               gc_nxt    = GC_W'(1);
               state_nxt = (LOCK_CNT <= 1) ? ST_LOCKED : ST_VERIFY;
            end
         end
         ST_VERIFY: begin
            if (errored) begin
               state_nxt = ST_HUNT;
               gc_nxt    = '0;
            end else begin
               gc_nxt = gc_inc;
               if (gc_inc >= GC_W'(LOCK_CNT)) state_nxt = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (win_err_new >= ERR_W'(ERR_THRESH)) begin
               state_nxt = ST_HUNT;
               drop      = 1'b1;
            end
         end
         default:   state_nxt = ST_RESET;
      endcase
      if (force_rst) begin
         state_nxt = ST_RESET;
         gc_nxt    = '0;
         swap_nxt  = 1'b0;
         drop      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RESET;
         gc    <= '0;
         swap  <= 1'b0;
      end else begin
         state <= state_nxt;
         gc    <= gc_nxt;
         swap  <= swap_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev        <= '0;
         prev_err    <= 1'b0;
         out_d       <= '0;
         out_valid   <= 1'b0;
         lane_locked <= 1'b0;
         relock_req  <= 1'b0;
         win_cnt     <= '0;
         win_err     <= '0;
      end else if (force_rst) begin
         prev        <= '0;
         prev_err    <= 1'b0;
         out_d       <= '0;
         out_valid   <= 1'b0;
         lane_locked <= 1'b0;
         relock_req  <= 1'b0;
         win_cnt     <= '0;
         win_err     <= '0;
      end else begin
         prev        <= rx_d;
         prev_err    <= errored;
         out_d       <= swap ? {rx_d[7:0], prev[15:8]} : rx_d;
         out_valid   <= (state == ST_LOCKED) && !errored && !(swap && prev_err);
         lane_locked <= (state_nxt == ST_LOCKED);
         relock_req  <= drop;
         if (state == ST_LOCKED && !drop) begin
            win_cnt <= win_cnt + WIN_W'(1);
            win_err <= win_err_new;
         end else begin
            win_cnt <= '0;
            win_err <= '0;
         end
      end
   end

`ifdef PFLINK_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt_q <= '0;
      else if (clr_cnt)
         err_cnt_q <= '0;
      else if (state != ST_RESET && errored && err_cnt_q != '1)
         err_cnt_q <= err_cnt_q + CNT_W'(1);
   end
   assign err_cnt = err_cnt_q;
`else
   logic unused_clr;
   assign unused_clr = clr_cnt;
   assign err_cnt    = '0;
`endif
endmodule

// File: rtl/pflink_rx_lane_monitor.sv
// Multi-lane PFLINK receive monitor: per-lane alignment/lock plus aggregate lock.
// Optional per-lane error counters are enabled with PFLINK_ERR_CNT_EN.
module pflink_rx_lane_monitor
   import pflink_pkg::*;
#(
   parameter int         N_LANES    = 4,
   parameter logic [7:0] COMMA_K    = COMMA_K_DEF,
   parameter int         LOCK_CNT   = 16,
   parameter int         ERR_THRESH = 4,
   parameter int         ERR_WINDOW = 256,
   parameter int         CNT_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [LANE_W*N_LANES-1:0]  rx_d,
   input  logic [2*N_LANES-1:0]       rx_k,
   input  logic [2*N_LANES-1:0]       rx_err,
   input  logic [N_LANES-1:0]         rx_reset_done,
   input  logic [N_LANES-1:0]         lane_en,
   input  logic                       clr_cnt,
   output logic [LANE_W*N_LANES-1:0]  out_d,
   output logic [N_LANES-1:0]         out_valid,
   output logic [N_LANES-1:0]         lane_locked,
   output logic                       all_locked,
   output logic [N_LANES-1:0]         relock_req,
   output logic [CNT_W*N_LANES-1:0]   err_cnt
);
   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      pflink_lane_fsm #(
         .COMMA_K    (COMMA_K),
         .LOCK_CNT   (LOCK_CNT),
         .ERR_THRESH (ERR_THRESH),
         .ERR_WINDOW (ERR_WINDOW),
         .CNT_W      (CNT_W)
      ) u_lane (
         .clk           (clk),
         .rst_n         (rst_n),
         .rx_d          (rx_d[LANE_W*i +: LANE_W]),
         .rx_k          (rx_k[2*i +: 2]),
         .rx_err        (rx_err[2*i +: 2]),
         .rx_reset_done (rx_reset_done[i]),
         .lane_en       (lane_en[i]),
         .clr_cnt       (clr_cnt),
         .out_d         (out_d[LANE_W*i +: LANE_W]),
         .out_valid     (out_valid[i]),
         .lane_locked   (lane_locked[i]),
         .relock_req    (relock_req[i]),
         .err_cnt       (err_cnt[CNT_W*i +: CNT_W])
      );
   end

   // Disabled lanes don't block aggregate lock, but an all-disabled link is never locked.
   assign all_locked = (|lane_en) && (&(lane_locked | ~lane_en));
endmodule
